// File: rtl/adder_share_seq.sv
// rtl/adder_share_seq.sv - two-requester wide adder built by sequencing one shared 3-bit adder slice.
// Optional ADDER_CHECK_EN adds a sticky chk_err result self-check against a behavioural sum.
module adder_share_seq #(
  parameter int DIGITS = 4,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [3*DIGITS-1:0] req0_a,
  input  logic [3*DIGITS-1:0] req0_b,
  input  logic                req0_cin,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [3*DIGITS-1:0] req1_a,
  input  logic [3*DIGITS-1:0] req1_b,
  input  logic                req1_cin,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [3*DIGITS-1:0] rsp_sum,
  output logic                rsp_cout,
  output logic [2:0]          add_a,
  output logic [2:0]          add_b,
  output logic                add_c0,
  input  logic [2:0]          add_s,
  input  logic                add_c3,
  output logic                busy
`ifdef ADDER_CHECK_EN
  , output logic              chk_err
`endif
);

  localparam int W  = 3 * DIGITS;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [DW-1:0]   r_digit;
  logic [SW-1:0]   r_cnt;
  logic            r_last_grant;

  logic            w_pick1;
  logic            w_any;
  logic            w_accept;
  logic            w_sample;
  logic            w_last;

  // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
  assign w_pick1  = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_any    = req0_valid | req1_valid;
  assign w_accept = (r_state == IDLE) & w_any;

  assign req0_ready = (r_state == IDLE) & req0_valid & ~w_pick1;
  assign req1_ready = (r_state == IDLE) & w_pick1;

  assign w_sample = (r_state == RUN) & (r_cnt == SW'(SETTLE - 1));
  assign w_last   = w_sample & (r_digit == DW'(DIGITS - 1));

  // Slice inputs come straight from the low digit of the operand shift registers.
  assign add_a  = r_a[2:0];
  assign add_b  = r_b[2:0];
  assign add_c0 = r_carry;
  assign busy   = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_carry      <= 1'b0;
      r_digit      <= '0;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a          <= w_pick1 ? req1_a : req0_a;
            r_b          <= w_pick1 ? req1_b : req0_b;
            r_carry      <= w_pick1 ? req1_cin : req0_cin;
            rsp_id       <= w_pick1;
            r_last_grant <= w_pick1;
            r_digit      <= '0;
            r_cnt        <= '0;
            r_state      <= RUN;
          end
        end
        RUN: begin
          if (w_sample) begin
            rsp_sum[3*r_digit +: 3] <= add_s;
            r_carry <= add_c3;
            r_a     <= r_a >> 3;
            r_b     <= r_b >> 3;
            r_digit <= r_digit + 1'b1;
            r_cnt   <= '0;
            if (w_last) begin
              rsp_cout  <= add_c3;
              rsp_valid <= 1'b1;
              r_state   <= DONE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_carry   <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ADDER_CHECK_EN
  logic [W-1:0] r_ca;
  logic [W-1:0] r_cb;
  logic         r_ccin;
  logic         r_chk_pend;

  // The comparison runs on the first DONE cycle, once the top digit and carry are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ca       <= '0;
      r_cb       <= '0;
      r_ccin     <= 1'b0;
      r_chk_pend <= 1'b0;
      chk_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ca   <= w_pick1 ? req1_a : req0_a;
        r_cb   <= w_pick1 ? req1_b : req0_b;
        r_ccin <= w_pick1 ? req1_cin : req0_cin;
      end
      if (w_last) begin
        r_chk_pend <= 1'b1;
      end else if (r_chk_pend) begin
        r_chk_pend <= 1'b0;
        if ({rsp_cout, rsp_sum} != ((W+1)'(r_ca) + (W+1)'(r_cb) + (W+1)'(r_ccin))) begin
          chk_err <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_adder_share_seq.sv
// tb/tb_adder_share_seq.sv - directed self-checking bench for adder_share_seq (DIGITS=4, SETTLE=2).
module tb_adder_share_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin;
  logic [11:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [11:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [11:0] rsp_sum;
  logic [2:0]  add_a, add_b, add_s;
  logic        add_c0, add_c3, busy;
  logic        flip;
  logic [3:0]  w_slice;
`ifdef ADDER_CHECK_EN
  logic        chk_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Ideal zero-delay slice, with an optional single-bit fault on the sum LSB.
  assign w_slice = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_c0};
  assign add_s   = w_slice[2:0] ^ {2'b00, flip};
  assign add_c3  = w_slice[3];

  adder_share_seq #(.DIGITS(4), .SETTLE(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .add_a(add_a), .add_b(add_b), .add_c0(add_c0), .add_s(add_s), .add_c3(add_c3),
    .busy(busy)
`ifdef ADDER_CHECK_EN
    , .chk_err(chk_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    if (!rsp_valid) check("rsp_timeout", 0, 1);
  endtask

  task automatic do_op(input int who, input logic [11:0] a, input logic [11:0] b, input logic cin,
                       input logic [11:0] es, input logic ec, input string tag);
    int n;
    if (who == 0) begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end
    #1;
    check({tag, "_rdy"},   (who == 0) ? req0_ready : req1_ready, 1);
    check({tag, "_other"}, (who == 0) ? req1_ready : req0_ready, 0);
    tick();
    if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_rsp(n);
    check({tag, "_lat"},  n, 8);
    check({tag, "_sum"},  rsp_sum, es);
    check({tag, "_cout"}, rsp_cout, ec);
    check({tag, "_id"},   rsp_id, who);
    tick();
    check({tag, "_vlow"}, rsp_valid, 0);
  endtask

  initial begin
    int n;
    logic [11:0] held_sum;
    rst = 1'b1; flip = 1'b0; rsp_ready = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", rsp_valid, 0);
    check("rst_busy",  busy, 0);
    check("rst_rdy0",  req0_ready, 0);
    check("rst_sum",   rsp_sum, 0);
    check("rst_adda",  {add_a, add_b, add_c0}, 0);

    do_op(0, 12'd4095, 12'd1, 1'b0, 12'd0, 1'b1, "wrap");
    do_op(0, 12'o5252, 12'o2525, 1'b1, 12'd0, 1'b1, "alt");
    check("idle_add", {add_a, add_b, add_c0}, 0);
    do_op(0, 12'd0, 12'd0, 1'b1, 12'd1, 1'b0, "cin");

    // Round-robin after a fresh reset.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    req0_a = 12'd5; req0_b = 12'd6; req0_cin = 0; req0_valid = 1'b1;
    req1_a = 12'd300; req1_b = 12'd200; req1_cin = 1; req1_valid = 1'b1;
    do_op(0, 12'd5, 12'd6, 1'b0, 12'd11, 1'b0, "rr0");
    do_op(1, 12'd300, 12'd200, 1'b1, 12'd501, 1'b0, "rr1");
    req0_valid = 1'b1; req1_valid = 1'b1;
    do_op(0, 12'd5, 12'd6, 1'b0, 12'd11, 1'b0, "rr2");
    req1_valid = 1'b0;

    // Backpressure with requester 0 kept waiting.
    rsp_ready = 1'b0;
    req0_a = 12'd7; req0_b = 12'd9; req0_cin = 0; req0_valid = 1'b1;
    #1;
    tick();
    wait_rsp(n);
    check("bp_lat", n, 8);
    check("bp_sum", rsp_sum, 12'd16);
    held_sum = rsp_sum;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", rsp_valid, 1);
      check("bp_hold",  rsp_sum, 12'd16);
      check("bp_id",    rsp_id, 0);
      check("bp_rdys",  {req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_gap_busy", busy, 0);
    check("bp_gap_vld",  rsp_valid, 0);
    check("bp_gap_rdy",  req0_ready, 1);
    tick();
    check("bp_next_busy", busy, 1);
    req0_valid = 1'b0;
    wait_rsp(n);
    check("bp_next_sum", rsp_sum, 12'd16);
    tick();

    // Asynchronous reset in the middle of digit 2.
    req0_a = 12'o1234; req0_b = 12'd0; req0_cin = 0; req0_valid = 1'b1;
    #1;
    tick();
    req0_valid = 1'b0;
    repeat (4) tick();
    check("mid_adda", add_a, 3'd2);
    check("mid_sum",  rsp_sum, 12'o0034);
    #2 rst = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_add",  {add_a, add_b, add_c0}, 0);
    check("mid_rsum", rsp_sum, 0);
    check("mid_vld",  rsp_valid, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    do_op(0, 12'd100, 12'd23, 1'b0, 12'd123, 1'b0, "post");

`ifdef ADDER_CHECK_EN
    check("chk_clean", chk_err, 0);
    req0_a = 0; req0_b = 0; req0_cin = 1; req0_valid = 1'b1;
    #1;
    tick();
    req0_valid = 1'b0;
    flip = 1'b1;
    tick(); tick();
    flip = 1'b0;
    wait_rsp(n);
    check("chk_badsum", rsp_sum, 12'd0);
    tick();
    check("chk_set", chk_err, 1);
    repeat (3) tick();
    check("chk_sticky", chk_err, 1);
    rst = 1'b1; #1;
    check("chk_clear", chk_err, 0);
    rst = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/adder_share_seq.md
Name: adder_share_seq

Overview:
- Sequences one shared 3-bit adder slice (add_a/add_b/add_c0 -> add_s/add_c3, RTL or gate-level) to perform wide additions of DIGITS 3-bit digits, least significant digit first.
- Chains add_c3 of each digit into add_c0 of the next.
- Arbitrates two requesters round-robin; returns one response at a time over a valid/ready channel.
- Waits a programmable number of cycles per digit so slow gate-level slices settle before sampling.

Parameters:
- DIGITS, 4, number of 3-bit digits per operand; operand width W = 3*DIGITS; must be >= 1.
- SETTLE, 2, cycles an operand digit is held on the slice before add_s/add_c3 are sampled; must be >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted on this edge when valid & ready.
- req0_a  in  W  operand A.
- req0_b  in  W  operand B.
- req0_cin  in  1  carry in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  requester that issued the result.
- rsp_sum  out  W  A+B+cin modulo 2^W.
- rsp_cout  out  1  carry out of the top digit.
- add_a  out  3  current A digit to the slice.
- add_b  out  3  current B digit to the slice.
- add_c0  out  1  current carry to the slice.
- add_s  in  3  slice sum.
- add_c3  in  1  slice carry out.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - state=IDLE; all outputs 0; internal operand, sum and carry registers 0.
  - last_grant=1, so requester 0 wins the first tie.
- States: IDLE, RUN, DONE.
- IDLE:
  - reqN_ready is combinational; only the winner's ready is high, and only in IDLE.
  - Winner is the single valid requester; if both are valid, the one not equal to last_grant.
  - On the edge with the winner's valid & ready:
    - latch a, b into shift registers and cin into the carry register.
    - set id; last_grant=id; digit=0; settle counter=0; go to RUN.
  - No valid requester: stay in IDLE, add_* held at 0.
- RUN:
  - add_a/add_b are the low digit of the shift registers; add_c0 = carry register. All three are registered and stable for SETTLE cycles per digit.
  - Settle counter counts 0..SETTLE-1. On the edge where counter==SETTLE-1:
    - write add_s into rsp_sum bits [3*digit+2:3*digit].
    - carry <= add_c3; shift operands right by 3; digit+1; counter=0.
  - On the edge sampling digit DIGITS-1: rsp_cout <= add_c3; go to DONE.
  - Requests are ignored; both readys stay low.
- DONE:
  - rsp_valid=1; rsp_sum, rsp_cout and rsp_id held stable until rsp_valid & rsp_ready.
  - On that edge: go to IDLE; rsp_valid=0 next cycle; add_* return to 0.
  - Accepting a new request in the same cycle as the response handshake is not allowed. Minimum gap is one IDLE cycle.
- Latency: rsp_valid rises exactly DIGITS*SETTLE cycles after the accept edge.
- rsp_sum keeps its last value after the handshake; it is only meaningful while rsp_valid is high.
- If a requester deasserts valid while not granted, nothing happens (no request is lost or queued).

Optional Feature:
- ADDER_CHECK_EN defined:
  - Adds full-width copies of a, b, cin and an output port chk_err (1 bit).
  - On entry to DONE, compares {rsp_cout, rsp_sum} with a+b+cin computed behaviourally.
  - chk_err is sticky high on mismatch and cleared only by rst.
- ADDER_CHECK_EN undefined: no chk_err port and no copy registers.

Test Plan:
- All tests use DIGITS=4, SETTLE=2, and an ideal slice model with zero delay.
- rst held high, then released: all outputs 0, busy=0, req0_ready=0 with no valid requester.
- req0 only, a=12'd4095, b=12'd1, cin=0 -> accepted in 1 cycle, rsp_valid 8 cycles later, rsp_sum=0, rsp_cout=1, rsp_id=0.
- a=12'o5252, b=12'o2525, cin=1 -> rsp_sum=0, rsp_cout=1. Separately a=0, b=0, cin=1 -> rsp_sum=1, rsp_cout=0.
- Round-robin: req0 and req1 both valid after reset -> requester 0 served first, then requester 1. Both valid again -> requester 0. Check rsp_id each time.
- Backpressure: rsp_ready low for 5 cycles in DONE -> rsp_valid, rsp_sum and rsp_id stable, both readys 0. Raise rsp_ready -> one IDLE cycle before the next accept.
- Reset mid-operation: assert rst during digit 2 -> outputs 0 immediately. A following request a=12'd100, b=12'd23, cin=0 -> rsp_sum=12'd123.
- With ADDER_CHECK_EN defined: flip add_s[0] for one digit in the slice model -> chk_err=1, and it stays 1 until rst.
